frame_bffr_wrtr: RTL and testbench

// - Write-side counterpart of the video line buffer: accepts a 24b pixel stream from the render path
//   and writes it into the system-memory frame region [SYS_MEM_START_ADDR..SYS_MEM_STOP_ADDR].
// - Decouples the stream from sys_mem_wait back-pressure with an internal sync FIFO.
// - Aligns every frame to START on SOF; one pixel per memory word.

---
 rtl/frame_bffr_wrtr.sv | 192 +++++++++++++++++++
 tb/tb_frame_bffr_wrtr.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bffr_wrtr.sv
// ----------------------------------------------------------------------------
// frame_bffr_wrtr
//   Write side of the video frame buffer. Takes a 24-bit pixel stream from the
//   render path and writes one pixel per memory word into the system-memory
//   frame region [SYS_MEM_START_ADDR .. SYS_MEM_STOP_ADDR]. An internal
//   first-word-fall-through FIFO decouples the stream from sys_mem_wait
//   back-pressure. Every SOF pixel is written to START, so each frame starts
//   at the top of the region.
//
//   Optional feature macro: FRAME_WRTR_STATS_EN
//     defined     : frame_cntr counts completed frames (wraps, cleared by rst)
//     not defined : frame_cntr is tied to zero
//
// Ports
//   clk, rst          system clock / asynchronous active-high reset
//   frame_wrtr_en     block enable; low flushes the FIFO and idles the block
//   pxl_valid/_sof    input pixel valid / first pixel of frame
//   pxl_data          pixel {R,G,B}
//   pxl_ready         input accept (transfer on pxl_valid & pxl_ready)
//   frame_done        1-cycle pulse after the STOP word is accepted
//   sof_err           sticky: SOF popped while the write pointer was not START
//   frame_cntr        completed-frame count (see macro above)
//   sys_mem_wait      memory stall; write accepted on wren & ~wait
//   sys_mem_wren      write request
//   sys_mem_rden      tied low
//   sys_mem_addr      word address (zero-extended)
//   sys_mem_wdata     {zeros, pixel}
// ----------------------------------------------------------------------------
module frame_bffr_wrtr #(
    parameter int SYS_MEM_DATA_W     = 32,
    parameter int SYS_MEM_ADDR_W     = 27,
    parameter int SYS_MEM_START_ADDR = 0,
    parameter int SYS_MEM_STOP_ADDR  = 921599,
    parameter int FF_DEPTH_W         = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_wrtr_en,
    input  logic                      pxl_valid,
    input  logic                      pxl_sof,
    input  logic [23:0]               pxl_data,
    output logic                      pxl_ready,
    output logic                      frame_done,
    output logic                      sof_err,
    output logic [15:0]               frame_cntr,
    input  logic                      sys_mem_wait,
    output logic                      sys_mem_wren,
    output logic                      sys_mem_rden,
    output logic [SYS_MEM_ADDR_W-1:0] sys_mem_addr,
    output logic [SYS_MEM_DATA_W-1:0] sys_mem_wdata
);

    localparam int PXL_NUM_CNTR_W = $clog2(SYS_MEM_STOP_ADDR + 1);
    localparam logic [PXL_NUM_CNTR_W-1:0] START_C = PXL_NUM_CNTR_W'(SYS_MEM_START_ADDR);
    localparam logic [PXL_NUM_CNTR_W-1:0] STOP_C  = PXL_NUM_CNTR_W'(SYS_MEM_STOP_ADDR);
    localparam int FF_N = 2 ** FF_DEPTH_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    // FIFO storage: {sof, pixel}; pointers carry one extra wrap bit
    logic [24:0]           ff_mem_q [FF_N];
    logic [FF_DEPTH_W:0]   wr_ptr_q, wr_ptr_d;
    logic [FF_DEPTH_W:0]   rd_ptr_q, rd_ptr_d;
    logic                  ff_empty, ff_full;
    logic                  push, pop;
    logic [24:0]           head;
    logic                  head_sof;
    logic [23:0]           head_pxl;

    logic [PXL_NUM_CNTR_W-1:0] pxl_cntr_q, pxl_cntr_d;
    logic [PXL_NUM_CNTR_W-1:0] wr_addr;
    logic                      sof_err_q, sof_err_d;
    logic                      frame_done_q, frame_done_d;

    assign ff_empty = (wr_ptr_q == rd_ptr_q);
    assign ff_full  = (wr_ptr_q[FF_DEPTH_W] != rd_ptr_q[FF_DEPTH_W]) &&
                      (wr_ptr_q[FF_DEPTH_W-1:0] == rd_ptr_q[FF_DEPTH_W-1:0]);

    // Head is masked when empty so the outputs show START/zero data at idle
    assign head     = ff_mem_q[rd_ptr_q[FF_DEPTH_W-1:0]];
    assign head_sof = ~ff_empty & head[24];
    assign head_pxl = ff_empty ? '0 : head[23:0];
    assign wr_addr  = head_sof ? START_C : pxl_cntr_q;

    assign sys_mem_wren  = frame_wrtr_en & (state_q == ST_RUN) & ~ff_empty;
    assign pop           = sys_mem_wren & ~sys_mem_wait;
    assign sys_mem_rden  = 1'b0;
    assign sys_mem_addr  = SYS_MEM_ADDR_W'(wr_addr);
    assign sys_mem_wdata = SYS_MEM_DATA_W'(head_pxl);
    assign frame_done    = frame_done_q;
    assign sof_err       = sof_err_q;

    // ------------------------------------------------------------------
    // Input FSM / push control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pxl_ready = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_SYNC;
            ST_SYNC: begin
                // Pixels before the first SOF are accepted and discarded
                pxl_ready = 1'b1;
                if (pxl_valid && pxl_sof) begin
                    push    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pxl_ready = ~ff_full;
                push      = pxl_valid & ~ff_full;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!frame_wrtr_en) begin
            state_d   = ST_IDLE;
            pxl_ready = 1'b0;
            push      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, address counter, status
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q + (FF_DEPTH_W + 1)'(push);
        rd_ptr_d     = rd_ptr_q + (FF_DEPTH_W + 1)'(pop);
        pxl_cntr_d   = pxl_cntr_q;
        sof_err_d    = sof_err_q;
        frame_done_d = 1'b0;
        if (pop) begin
            pxl_cntr_d   = (wr_addr == STOP_C) ? START_C : wr_addr + PXL_NUM_CNTR_W'(1);
            frame_done_d = (wr_addr == STOP_C);
            if (head_sof && (pxl_cntr_q != START_C)) begin
                sof_err_d = 1'b1;
            end
        end
        if (!frame_wrtr_en) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pxl_cntr_d = START_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pxl_cntr_q   <= START_C;
            sof_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pxl_cntr_q   <= pxl_cntr_d;
            sof_err_q    <= sof_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ff_mem_q[wr_ptr_q[FF_DEPTH_W-1:0]] <= {pxl_sof, pxl_data};
        end
    end

`ifdef FRAME_WRTR_STATS_EN
    logic [15:0] frame_cntr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cntr_q <= '0;
        end else if (frame_done_q) begin
            frame_cntr_q <= frame_cntr_q + 16'd1;
        end
    end

    assign frame_cntr = frame_cntr_q;
`else
    assign frame_cntr = '0;
`endif

endmodule

// File: tb/tb_frame_bffr_wrtr.sv
// ----------------------------------------------------------------------------
// tb_frame_bffr_wrtr
//   Directed bench for frame_bffr_wrtr with START=0, STOP=7, FF_DEPTH_W=2.
//   Inputs change 1 time unit after the rising edge; memory writes and
//   frame_done pulses are logged on the falling edge.
// ----------------------------------------------------------------------------
module tb_frame_bffr_wrtr;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_wrtr_en;
    logic        pxl_valid;
    logic        pxl_sof;
    logic [23:0] pxl_data;
    logic        pxl_ready;
    logic        frame_done;
    logic        sof_err;
    logic [15:0] frame_cntr;
    logic        sys_mem_wait;
    logic        sys_mem_wren;
    logic        sys_mem_rden;
    logic [26:0] sys_mem_addr;
    logic [31:0] sys_mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [26:0] log_addr [256];
    logic [31:0] log_data [256];
    int          wr_n   = 0;
    int          done_n = 0;

    frame_bffr_wrtr #(
        .SYS_MEM_DATA_W     (32),
        .SYS_MEM_ADDR_W     (27),
        .SYS_MEM_START_ADDR (0),
        .SYS_MEM_STOP_ADDR  (7),
        .FF_DEPTH_W         (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_wrtr_en (frame_wrtr_en),
        .pxl_valid     (pxl_valid),
        .pxl_sof       (pxl_sof),
        .pxl_data      (pxl_data),
        .pxl_ready     (pxl_ready),
        .frame_done    (frame_done),
        .sof_err       (sof_err),
        .frame_cntr    (frame_cntr),
        .sys_mem_wait  (sys_mem_wait),
        .sys_mem_wren  (sys_mem_wren),
        .sys_mem_rden  (sys_mem_rden),
        .sys_mem_addr  (sys_mem_addr),
        .sys_mem_wdata (sys_mem_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (sys_mem_wren && !sys_mem_wait && wr_n < 256) begin
                log_addr[wr_n] <= sys_mem_addr;
                log_data[wr_n] <= sys_mem_wdata;
                wr_n           <= wr_n + 1;
            end
            if (frame_done) begin
                done_n <= done_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one pixel and hold it until accepted (bounded)
    task automatic send(input logic sof, input logic [23:0] d);
        int   n   = 0;
        logic acc = 1'b0;
        pxl_valid = 1'b1;
        pxl_sof   = sof;
        pxl_data  = d;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = pxl_ready;
            @(posedge clk);
            #1;
            n++;
        end
        pxl_valid = 1'b0;
        pxl_sof   = 1'b0;
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    // Compare 'n' logged writes starting at log index 'b' against addr a0+i, data d0+i
    task automatic check_log(input string tag, input int b, input int n,
                             input logic [31:0] a0, input logic [31:0] d0);
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, 32'(log_addr[b+i]), a0 + 32'(i));
            check({tag, "_data"}, log_data[b+i], d0 + 32'(i));
        end
    endtask

    initial begin
        int   b;
        int   d;
        logic stable_ok;

        rst           = 1'b1;
        frame_wrtr_en = 1'b0;
        pxl_valid     = 1'b0;
        pxl_sof       = 1'b0;
        pxl_data      = '0;
        sys_mem_wait  = 1'b0;
        tick(2);

        // Reset state
        check("rst_ready", 32'(pxl_ready), 32'd0);
        check("rst_wren", 32'(sys_mem_wren), 32'd0);
        check("rst_rden", 32'(sys_mem_rden), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_soferr", 32'(sof_err), 32'd0);
        check("rst_fcntr", 32'(frame_cntr), 32'd0);
        check("rst_addr", 32'(sys_mem_addr), 32'd0);
        check("rst_wdata", sys_mem_wdata, 32'd0);
        rst = 1'b0;
        tick(1);

        // 1: plain frame of 8 pixels
        b = wr_n; d = done_n;
        frame_wrtr_en = 1'b1;
        send(1'b1, 24'h000001);
        check("t1_latency_wren", 32'(sys_mem_wren), 32'd1);
        check("t1_latency_addr", 32'(sys_mem_addr), 32'd0);
        check("t1_latency_data", sys_mem_wdata, 32'd1);
        for (int i = 2; i <= 8; i++) send(1'b0, 24'(i));
        tick(6);
        check("t1_nwr", 32'(wr_n - b), 32'd8);
        check_log("t1", b, 8, 32'd0, 32'd1);
        check("t1_done", 32'(done_n - d), 32'd1);
        check("t1_soferr", 32'(sof_err), 32'd0);

        // 2: pre-SOF pixels after re-enable are dropped
        frame_wrtr_en = 1'b0;
        tick(2);
        frame_wrtr_en = 1'b1;
        b = wr_n; d = done_n;
        for (int i = 0; i < 3; i++) send(1'b0, 24'hA0 + 24'(i));
        tick(2);
        check("t2_presof_nwr", 32'(wr_n - b), 32'd0);
        send(1'b1, 24'h10);
        for (int i = 1; i < 8; i++) send(1'b0, 24'h10 + 24'(i));
        tick(6);
        check("t2_nwr", 32'(wr_n - b), 32'd8);
        check_log("t2", b, 8, 32'd0, 32'h10);
        check("t2_done", 32'(done_n - d), 32'd1);

        // 3: memory stall mid-frame
        b = wr_n; d = done_n;
        send(1'b1, 24'h20);
        send(1'b0, 24'h21);
        send(1'b0, 24'h22);
        sys_mem_wait = 1'b1;
        send(1'b0, 24'h23);
        send(1'b0, 24'h24);
        send(1'b0, 24'h25);
        stable_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (!(sys_mem_wren === 1'b1 && sys_mem_addr === 27'd2 &&
                  sys_mem_wdata === 32'h22 && pxl_ready === 1'b0))
                stable_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check("t3_stall_stable", 32'(stable_ok), 32'd1);
        check("t3_full_ready", 32'(pxl_ready), 32'd0);
        check("t3_stall_nwr", 32'(wr_n - b), 32'd2);
        sys_mem_wait = 1'b0;
        send(1'b0, 24'h26);
        send(1'b0, 24'h27);
        tick(8);
        check("t3_nwr", 32'(wr_n - b), 32'd8);
        check_log("t3", b, 8, 32'd0, 32'h20);
        check("t3_done", 32'(done_n - d), 32'd1);
        check("t3_soferr", 32'(sof_err), 32'd0);

        // 4: short frame followed by SOF
        b = wr_n; d = done_n;
        send(1'b1, 24'h30);
        for (int i = 1; i < 5; i++) send(1'b0, 24'h30 + 24'(i));
        send(1'b1, 24'h40);
        for (int i = 1; i < 8; i++) send(1'b0, 24'h40 + 24'(i));
        tick(6);
        check("t4_nwr", 32'(wr_n - b), 32'd13);
        check_log("t4_short", b, 5, 32'd0, 32'h30);
        check_log("t4_full", b + 5, 8, 32'd0, 32'h40);
        check("t4_soferr", 32'(sof_err), 32'd1);
        check("t4_done", 32'(done_n - d), 32'd1);

        // 5: disable mid-frame with FIFO non-empty
        b = wr_n; d = done_n;
        send(1'b1, 24'h50);
        for (int i = 1; i < 4; i++) send(1'b0, 24'h50 + 24'(i));
        sys_mem_wait = 1'b1;
        send(1'b0, 24'h54);
        check("t5_pre_addr", 32'(sys_mem_addr), 32'd3);
        frame_wrtr_en = 1'b0;
        #1;
        check("t5_dis_wren", 32'(sys_mem_wren), 32'd0);
        check("t5_dis_ready", 32'(pxl_ready), 32'd0);
        tick(2);
        sys_mem_wait  = 1'b0;
        frame_wrtr_en = 1'b1;
        send(1'b0, 24'h55);
        tick(2);
        check("t5_flush_nwr", 32'(wr_n - b), 32'd3);
        send(1'b1, 24'h60);
        for (int i = 1; i < 8; i++) send(1'b0, 24'h60 + 24'(i));
        tick(6);
        check("t5_nwr", 32'(wr_n - b), 32'd11);
        check_log("t5", b + 3, 8, 32'd0, 32'h60);
        check("t5_done", 32'(done_n - d), 32'd1);
        check("t5_soferr_kept", 32'(sof_err), 32'd1);

`ifdef FRAME_WRTR_STATS_EN
        check("frame_cntr", 32'(frame_cntr), 32'd5);
`else
        check("frame_cntr", 32'(frame_cntr), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
